// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state codes, retry counter width
// and a small helper for sizing the shared cycle counter.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_PCS   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; all flops clear to 0 on reset
// so a stale "locked" can never be seen right after reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL startup/recovery controller: pulses the PLL reset, qualifies synchronized lock, then
// releases PCS reset and later MAC reset; any lock loss or lock timeout re-resets the PLL.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 64,
    parameter int SYNC_STAGES        = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_pll_locked,
    output logic               o_pll_reset,
    output logic               o_rst_pcs,
    output logic               o_rst_mac,
    output logic               o_ready,
    output logic [RETRY_W-1:0] o_retry_count,
    output logic [STATE_W-1:0] o_state
);

    localparam int CNT_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                    max_of(LOCK_STABLE_CYCLES, STAGE_GAP));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

    logic               lock_s;
    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               retry_inc;
    logic               pll_reset_q, pll_reset_d;
    logic               rst_pcs_q, rst_pcs_d;
    logic               rst_mac_q, rst_mac_d;
    logic               ready_q, ready_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (i_clk),
        .rst_i (i_reset),
        .d_i   (i_pll_locked),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                // A dropout only restarts the lock wait; the PLL has not failed yet.
                if (!lock_s)                   state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_REL_PCS;
            end
            ST_REL_PCS: begin
                if (!lock_s) begin
                    state_d   = ST_PLL_RST;
                    retry_inc = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d   = ST_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase

        cnt_d = ((state_d != state_q) || (state_q == ST_RUN)) ? '0 : cnt_q + CNT_W'(1);

        retry_d = (retry_inc && (retry_q != '1)) ? retry_q + RETRY_W'(1) : retry_q;

        // Outputs are decoded from the next state so they register alongside it.
        pll_reset_d = (state_d == ST_PLL_RST);
        rst_pcs_d   = (state_d == ST_PLL_RST) || (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);
        rst_mac_d   = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            rst_pcs_q   <= 1'b1;
            rst_mac_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            rst_pcs_q   <= rst_pcs_d;
            rst_mac_q   <= rst_mac_d;
            ready_q     <= ready_d;
        end
    end

    assign o_pll_reset   = pll_reset_q;
    assign o_rst_pcs     = rst_pcs_q;
    assign o_rst_mac     = rst_mac_q;
    assign o_ready       = ready_q;
    assign o_retry_count = retry_q;
    assign o_state       = state_q;

endmodule
